// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// N_BITS is pinned to the width of the single shared add_huit adder.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int N_BITS    = 8;
  localparam int LAST_ITER = N_BITS - 1;

endpackage

// File: rtl/add_huit.sv
// 8-bit ripple-carry adder: s = a + b + rin, carry out on rout.
// Purely combinational, no handshake.
module add_huit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       rin,
  output logic [7:0] s,
  output logic       rout
);

  logic [8:0] c;

  assign c[0] = rin;

  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign rout = c[8];

endmodule

// File: rtl/mult_seq_ctrl.sv
// 8x8 unsigned shift-add multiplier on one shared add_huit; done 9 cycles after accept.
// start is ignored while busy; MULT_SEQ_ZERO_BYPASS_EN lets zero operands finish in 1 cycle.
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int N_BITS = 8,
  parameter int CNT_W  = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [7:0]   a,
  input  logic [7:0]   b,
  output logic         busy,
  output logic         done,
  output logic [15:0]  m
);

  if (N_BITS != 8) begin : g_bad_width
    $error("mult_seq_ctrl: N_BITS must be 8 to match add_huit");
  end
  if ((1 << CNT_W) <= LAST_ITER) begin : g_bad_cnt
    $error("mult_seq_ctrl: CNT_W too narrow for N_BITS iterations");
  end

  state_t           state;
  logic [7:0]       p_q;
  logic [7:0]       q_q;
  logic [7:0]       m_q;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       sum;
  logic             c;
  logic             zero_bypass;

  add_huit u_add (
    .a    (p_q),
    .b    (q_q[0] ? m_q : 8'h00),
    .rin  (1'b0),
    .s    (sum),
    .rout (c)
  );

`ifdef MULT_SEQ_ZERO_BYPASS_EN
  assign zero_bypass = (a == 8'h00) || (b == 8'h00);
`else
  assign zero_bypass = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      p_q   <= '0;
      q_q   <= '0;
      m_q   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      m     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            m_q <= b;
            q_q <= a;
            p_q <= '0;
            cnt <= '0;
            if (zero_bypass) begin
              state <= DONE;
              done  <= 1'b1;
              m     <= '0;
            end else begin
              state <= CALC;
              busy  <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          // Right-shift {c,sum,Q}: the carry lands in the top of P each step.
          p_q <= {c, sum[7:1]};
          q_q <= {sum[0], q_q[7:1]};
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(LAST_ITER)) begin
            m     <= {c, sum, q_q[7:1]};
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl: handshake timing, products, reset abort, held start.
module tb_mult_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] m;

  int checks   = 0;
  int failures = 0;

  mult_seq_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .m     (m)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Starts one op, then observes 14 cycles; optionally pulses start (a=b=9) at idx intrude.
  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input int intrude,
                        output int busy_n, output int done_first, output int done_n,
                        output logic m_stable);
    logic [15:0] m_before;
    m_before   = m;
    busy_n     = 0;
    done_first = -1;
    done_n     = 0;
    m_stable   = 1'b1;
    a = ia; b = ib; start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      if (i == intrude) begin start = 1'b1; a = 8'd9; b = 8'd9; end
      if (i == intrude + 1) start = 1'b0;
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1) begin
        done_n++;
        if (done_first < 0) done_first = i;
      end
      if (done_first < 0 && m !== m_before) m_stable = 1'b0;
      tick;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00;
    #12;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (m !== 16'h0000) begin failures++; $display("FAIL reset_m got=%h exp=0000", m); end
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_basic;
    int bn, df, dn; logic st;
    run_op(8'd13, 8'd11, -10, bn, df, dn, st);
    checks++; if (m !== 16'd143) begin failures++; $display("FAIL basic_m got=%0d exp=143", m); end
    checks++; if (bn != 8) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=8", bn); end
    checks++; if (df != 9) begin failures++; $display("FAIL basic_done_latency got=%0d exp=9", df); end
    checks++; if (dn != 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", dn); end
    checks++; if (st !== 1'b1) begin failures++; $display("FAIL basic_m_stable got=%b exp=1", st); end
  endtask

  task automatic test_max;
    int bn, df, dn; logic st;
    run_op(8'hFF, 8'hFF, -10, bn, df, dn, st);
    checks++; if (m !== 16'hFE01) begin failures++; $display("FAIL max_m got=%h exp=fe01", m); end
    checks++; if (m[15] !== 1'b1) begin failures++; $display("FAIL max_m15 got=%b exp=1", m[15]); end
    checks++; if (dn != 1) begin failures++; $display("FAIL max_done_width got=%0d exp=1", dn); end
    checks++; if (df != 9) begin failures++; $display("FAIL max_done_latency got=%0d exp=9", df); end
  endtask

  task automatic test_start_while_busy;
    int bn, df, dn; logic st;
    run_op(8'd5, 8'd7, 3, bn, df, dn, st);
    checks++; if (m !== 16'd35) begin failures++; $display("FAIL busy_start_m got=%0d exp=35", m); end
    checks++; if (dn != 1) begin failures++; $display("FAIL busy_start_done_count got=%0d exp=1", dn); end
    checks++; if (df != 9) begin failures++; $display("FAIL busy_start_latency got=%0d exp=9", df); end
  endtask

  task automatic test_reset_abort;
    int bn, df, dn, dseen; logic st;
    a = 8'd200; b = 8'd3; start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick; tick;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL abort_busy_before got=%b exp=1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (m !== 16'h0000) begin failures++; $display("FAIL abort_m got=%h exp=0000", m); end
    dseen = 0;
    for (int i = 0; i < 10; i++) begin
      if (done === 1'b1) dseen++;
      if (i == 2) rst_n = 1'b1;
      tick;
    end
    checks++; if (dseen != 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", dseen); end
    run_op(8'd3, 8'd4, -10, bn, df, dn, st);
    checks++; if (m !== 16'd12) begin failures++; $display("FAIL abort_next_m got=%0d exp=12", m); end
    checks++; if (df != 9) begin failures++; $display("FAIL abort_next_latency got=%0d exp=9", df); end
  endtask

  task automatic test_back_to_back;
    int d1, d2, dn;
    logic [15:0] m1, m2;
    d1 = -1; d2 = -1; dn = 0; m1 = '0; m2 = '0;
    a = 8'd2; b = 8'd3; start = 1'b1;
    tick;
    a = 8'd10; b = 8'd10;
    for (int i = 1; i <= 22; i++) begin
      if (done === 1'b1) begin
        dn++;
        if (d1 < 0) begin d1 = i; m1 = m; end
        else if (d2 < 0) begin d2 = i; m2 = m; end
      end
      if (i == 18) start = 1'b0;
      tick;
    end
    checks++; if (d1 != 9) begin failures++; $display("FAIL b2b_first_done got=%0d exp=9", d1); end
    checks++; if (d2 != 18) begin failures++; $display("FAIL b2b_second_done got=%0d exp=18", d2); end
    checks++; if (m1 !== 16'd6) begin failures++; $display("FAIL b2b_m1 got=%0d exp=6", m1); end
    checks++; if (m2 !== 16'd100) begin failures++; $display("FAIL b2b_m2 got=%0d exp=100", m2); end
    checks++; if (dn != 2) begin failures++; $display("FAIL b2b_done_count got=%0d exp=2", dn); end
  endtask

  task automatic test_zero_operand;
    int bn, df, dn; logic st;
    int exp_df, exp_bn;
`ifdef MULT_SEQ_ZERO_BYPASS_EN
    exp_df = 1; exp_bn = 0;
`else
    exp_df = 9; exp_bn = 8;
`endif
    run_op(8'h00, 8'hAB, -10, bn, df, dn, st);
    checks++; if (m !== 16'h0000) begin failures++; $display("FAIL zero_m got=%h exp=0000", m); end
    checks++; if (df != exp_df) begin failures++; $display("FAIL zero_latency got=%0d exp=%0d", df, exp_df); end
    checks++; if (bn != exp_bn) begin failures++; $display("FAIL zero_busy_cycles got=%0d exp=%0d", bn, exp_bn); end
    checks++; if (dn != 1) begin failures++; $display("FAIL zero_done_count got=%0d exp=1", dn); end
    checks++; if (st !== 1'b1) begin failures++; $display("FAIL zero_m_stable got=%b exp=1", st); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_max;
    test_start_while_busy;
    test_reset_abort;
    test_back_to_back;
    test_zero_operand;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout simulation exceeded 20000 time units");
    $fatal(1);
  end

endmodule
